serial_summator: RTL and testbench
==================================

Name: serial_summator

Overview:
Bit-serial adder/subtractor for two WIDTH-bit operands.
- Latches both operands on a start handshake.
- Computes the result one bit per clock, LSB first, with a single full adder and a carry flip-flop.
- Streams the result bits out with valid/last qualifiers, then presents the full (WIDTH+1)-bit result in parallel.
- Used wherever the datapath serialises arithmetic results to save area; replaces the fixed-width shift-out summator with a parametrised, handshaked, add/sub block.

Parameters:
WIDTH, 8, operand width in bits (minimum 1)

Ports:
clk  in  1  clock; all state changes on its rising edge
reset  in  1  synchronous, active-high reset
start  in  1  request to begin an operation; sampled only while busy=0
a  in  WIDTH  operand A (unsigned or two's complement), sampled with start
b  in  WIDTH  operand B, sampled with start
sub  in  1  0 = A+B, 1 = A-B; sampled with start
busy  out  1  high from the edge accepting start through the edge producing the last bit
sum_bit  out  1  current serial result bit
sum_valid  out  1  sum_bit is valid this cycle
sum_last  out  1  marks bit WIDTH-1 (the MSB) of the serial stream
done  out  1  one-cycle pulse, coincident with sum_last
sum_word  out  WIDTH+1  parallel result {final carry, WIDTH result bits}; held until the next done

Behaviour:
- Reset (synchronous, active-high, has priority over everything):
  - State goes to IDLE.
  - busy, sum_bit, sum_valid, sum_last, done = 0; sum_word = 0.
  - Internal shift registers, carry and bit counter are cleared.
- State machine has two states, IDLE and SHIFT.
- IDLE, start=1 at edge E0:
  - opA <= a; opB <= (sub ? ~b : b); carry <= sub; counter <= 0; state <= SHIFT; busy <= 1.
  - sum_valid stays 0 at E0.
- SHIFT, edge Ek for k = 1..WIDTH:
  - Computes s = opA[0]^opB[0]^carry and carry <= majority(opA[0], opB[0], carry).
  - Registers sum_bit <= s and sum_valid <= 1.
  - Shifts opA and opB right by 1; shifts s into the top of the result shift register; counter increments.
- At edge E_WIDTH (the counter reaches WIDTH-1 before the edge):
  - sum_last <= 1, done <= 1.
  - sum_word <= {final carry, assembled result}.
  - state <= IDLE, busy <= 0.
- Edge after E_WIDTH: sum_valid, sum_last and done return to 0. sum_bit holds its last value (don't-care while sum_valid=0).
- Latency:
  - First result bit is valid in the cycle after E1.
  - done is visible WIDTH cycles after the start-accept edge.
  - Throughput is one operation per WIDTH+1 cycles: a new start is sampled at E_WIDTH+1 at the earliest.
- start while busy=1 is ignored. The operation in progress continues unaffected, and a, b, sub changes are ignored.
- Subtraction arithmetic:
  - Computed as A + ~B + 1.
  - sum_word[WIDTH] = 1 means no borrow (A >= B unsigned); 0 means borrow.
- Addition arithmetic: sum_word[WIDTH] is the unsigned carry-out, so sum_word equals the exact unsigned sum.
- WIDTH=1: one SHIFT edge; sum_valid, sum_last and done all assert in the same cycle.
- Reset mid-operation: the operation is aborted, no done is produced, sum_word is cleared to 0, and the block is ready for start on the next edge after reset deasserts.

Optional Feature:
SERIAL_SUMMATOR_OVF_EN
- Defined:
  - Adds port overflow (out, 1): signed two's-complement overflow = (carry into MSB) XOR (carry out of MSB).
  - overflow is registered at E_WIDTH alongside sum_word and held until the next done.
  - Reset clears it to 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- WIDTH=4, a=5, b=3, sub=0 -> serial bits 0,0,0,1 (LSB first); sum_last and done on the 4th bit; sum_word=0x08; busy high for exactly 4 cycles.
- WIDTH=4, a=15, b=1, sub=0 -> bits 0,0,0,0; sum_word=0x10 (carry-out=1).
- WIDTH=4, a=3, b=5, sub=1 -> bits 0,1,1,1; sum_word=0x0E (borrow, bit4=0). Follow with a=7, b=2, sub=1 -> sum_word=0x15.
- start held high continuously with changing a/b -> only operations accepted while busy=0 execute; back-to-back accepts are exactly 5 cycles apart for WIDTH=4; results match the operands captured at each accept.
- Assert reset after the 2nd serial bit of a=9, b=6 -> no done, sum_word=0, sum_valid=0 next cycle; a new start 1 cycle after reset deasserts computes correctly.
- With SERIAL_SUMMATOR_OVF_EN, WIDTH=4: a=7, b=1, sub=0 -> overflow=1, sum_word=0x08; a=-8 (0x8), b=1, sub=1 -> overflow=1; a=2, b=3, sub=0 -> overflow=0.

Source files
------------

// File: rtl/serial_summator.sv
// Bit-serial adder/subtractor, one result bit per clock, LSB first.
// Define SERIAL_SUMMATOR_OVF_EN to add the signed overflow output.
module serial_summator #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             busy,
  output logic             sum_bit,
  output logic             sum_valid,
  output logic             sum_last,
  output logic             done,
  output logic [WIDTH:0]   sum_word
`ifdef SERIAL_SUMMATOR_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_nxt;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             s;
  logic             c_nxt;
  logic             fin;

  assign s     = opa[0] ^ opb[0] ^ carry;
  assign c_nxt = (opa[0] & opb[0]) |
                 (opa[0] & carry)  |
                 (opb[0] & carry);
  assign fin   = (cnt == LAST);

  // New bit enters at the top so the LSB ends up at bit 0.
  assign res_nxt = (res >> 1) |
                   (WIDTH'(s) << (WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      opa       <= '0;
      opb       <= '0;
      res       <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      busy      <= 1'b0;
      sum_bit   <= 1'b0;
      sum_valid <= 1'b0;
      sum_last  <= 1'b0;
      done      <= 1'b0;
      sum_word  <= '0;
`ifdef SERIAL_SUMMATOR_OVF_EN
      overflow  <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          sum_valid <= 1'b0;
          sum_last  <= 1'b0;
          done      <= 1'b0;
          if (start) begin
            opa   <= a;
            opb   <= sub ? ~b : b;
            carry <= sub;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          sum_bit   <= s;
          sum_valid <= 1'b1;
          carry     <= c_nxt;
          opa       <= opa >> 1;
          opb       <= opb >> 1;
          res       <= res_nxt;
          cnt       <= cnt + CW'(1);
          sum_last  <= fin;
          done      <= fin;
          if (fin) begin
            sum_word <= {c_nxt, res_nxt};
`ifdef SERIAL_SUMMATOR_OVF_EN
            overflow <= carry ^ c_nxt;
`endif
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_summator.sv
// Self-checking bench for serial_summator at WIDTH=4.
// Checks overflow too when SERIAL_SUMMATOR_OVF_EN is defined.
module tb_serial_summator;

  localparam int W = 4;
  localparam int M = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         busy;
  logic         sum_bit;
  logic         sum_valid;
  logic         sum_last;
  logic         done;
  logic [W:0]   sum_word;
`ifdef SERIAL_SUMMATOR_OVF_EN
  logic         overflow;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_summator #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .busy      (busy),
    .sum_bit   (sum_bit),
    .sum_valid (sum_valid),
    .sum_last  (sum_last),
    .done      (done),
    .sum_word  (sum_word)
`ifdef SERIAL_SUMMATOR_OVF_EN
    ,
    .overflow  (overflow)
`endif
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W:0]   word;
    logic         ovf;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string nm,
                     input int act,
                     input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d",
               nm, act, exp);
    end
  endtask

  function automatic int model_word(input int x,
                                    input int y,
                                    input int s);
    if (s != 0)
      return (x + ((~y) & M) + 1) & ((M << 1) | 1);
    return x + y;
  endfunction

  function automatic int model_ovf(input int x,
                                   input int y,
                                   input int s);
    int sx;
    int sy;
    int r;
    sx = (x > M / 2) ? x - (M + 1) : x;
    sy = (y > M / 2) ? y - (M + 1) : y;
    r  = (s != 0) ? sx - sy : sx + sy;
    return ((r > M / 2) || (r < -(M + 1) / 2)) ? 1 : 0;
  endfunction

  task automatic run_op(input logic [W-1:0] ta,
                        input logic [W-1:0] tb,
                        input logic ts,
                        input int ew,
                        input int eo);
    start = 1'b1;
    a     = ta;
    b     = tb;
    sub   = ts;
    @(posedge clk); #1;
    chk("e0_busy", busy, 1);
    chk("e0_valid", sum_valid, 0);
    // Junk on the inputs while busy must be ignored.
    start = 1'b1;
    a     = W'($urandom);
    b     = W'($urandom);
    sub   = 1'($urandom);
    for (int k = 1; k <= W; k++) begin
      @(posedge clk); #1;
      chk("valid", sum_valid, 1);
      chk("bit", sum_bit, (ew >> (k - 1)) & 1);
      chk("last", sum_last, (k == W) ? 1 : 0);
      chk("done", done, (k == W) ? 1 : 0);
      chk("busy", busy, (k == W) ? 0 : 1);
    end
    start = 1'b0;
    chk("word", sum_word, ew);
`ifdef SERIAL_SUMMATOR_OVF_EN
    chk("ovf", overflow, eo);
`else
    if (eo < 0) chk("ovf_arg", eo, 0);
`endif
    @(posedge clk); #1;
    chk("post_valid", sum_valid, 0);
    chk("post_done", done, 0);
    chk("post_last", sum_last, 0);
    chk("post_busy", busy, 0);
    chk("post_word", sum_word, ew);
  endtask

  initial begin
    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];
    logic         qs[$];
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rs;

    vt[0] = '{4'd5,  4'd3, 1'b0, 5'h08, 1'b1};
    vt[1] = '{4'd15, 4'd1, 1'b0, 5'h10, 1'b0};
    vt[2] = '{4'd3,  4'd5, 1'b1, 5'h0E, 1'b0};
    vt[3] = '{4'd7,  4'd2, 1'b1, 5'h15, 1'b0};
    vt[4] = '{4'd7,  4'd1, 1'b0, 5'h08, 1'b1};
    vt[5] = '{4'h8,  4'd1, 1'b1, 5'h17, 1'b1};
    vt[6] = '{4'd2,  4'd3, 1'b0, 5'h05, 1'b0};
    vt[7] = '{4'd0,  4'd0, 1'b1, 5'h10, 1'b0};

    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    sub   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", sum_valid, 0);
    chk("rst_last", sum_last, 0);
    chk("rst_done", done, 0);
    chk("rst_word", sum_word, 0);
`ifdef SERIAL_SUMMATOR_OVF_EN
    chk("rst_ovf", overflow, 0);
`endif
    reset = 1'b0;

    for (int i = 0; i < 8; i++)
      run_op(vt[i].a, vt[i].b, vt[i].sub,
             int'(vt[i].word), int'(vt[i].ovf));

    for (int i = 0; i < 30; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'($urandom);
      run_op(ra, rb, rs,
             model_word(ra, rb, rs),
             model_ovf(ra, rb, rs));
    end

    // start held high: accepts land every W+1 edges.
    start = 1'b1;
    for (int c = 0; c < 3 * (W + 1); c++) begin
      a   = W'($urandom);
      b   = W'($urandom);
      sub = 1'($urandom);
      if (c % (W + 1) == 0) begin
        qa.push_back(a);
        qb.push_back(b);
        qs.push_back(sub);
      end
      @(posedge clk); #1;
      if (c == 3 * (W + 1) - 1) start = 1'b0;
      chk("bb_busy", busy,
          (c % (W + 1) == W) ? 0 : 1);
      chk("bb_done", done,
          (c % (W + 1) == W) ? 1 : 0);
      if (c % (W + 1) == W) begin
        chk("bb_word", sum_word,
            model_word(qa[0], qb[0], qs[0]));
        void'(qa.pop_front());
        void'(qb.pop_front());
        void'(qs.pop_front());
      end
    end
    @(posedge clk); #1;
    chk("bb_idle", busy, 0);

    // Reset after the second serial bit of 9+6.
    start = 1'b1;
    a     = 4'd9;
    b     = 4'd6;
    sub   = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("ab_bit0", sum_bit, 1);
    @(posedge clk); #1;
    chk("ab_bit1", sum_bit, 1);
    chk("ab_valid1", sum_valid, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("ab_valid", sum_valid, 0);
    chk("ab_done", done, 0);
    chk("ab_word", sum_word, 0);
    chk("ab_busy", busy, 0);
    run_op(4'd9, 4'd6, 1'b0,
           model_word(9, 6, 0), model_ovf(9, 6, 0));

    // Subtraction borrow boundary.
    run_op(4'd6, 4'd6, 1'b1,
           model_word(6, 6, 1), model_ovf(6, 6, 1));
    run_op(4'd0, 4'd15, 1'b1,
           model_word(0, 15, 1), model_ovf(0, 15, 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
